// File: rtl/input_map_pkg.sv
// Shared definitions for the memory-mapped input path.
// Contents:
//   ADDR_IR / ADDR_SW / ADDR_EVT : load-mux word addresses (29, 30, 31)
//   NUM_SW                       : number of switch/button lines
//   db_state_e                   : per-bit debounce state {STABLE, COUNTING}
//   pack_evt()                   : event register readback layout
package input_map_pkg;

  localparam logic [4:0] ADDR_IR  = 5'd29;
  localparam logic [4:0] ADDR_SW  = 5'd30;
  localparam logic [4:0] ADDR_EVT = 5'd31;

  localparam int NUM_SW = 5;

  typedef enum logic {
    STABLE   = 1'b0,
    COUNTING = 1'b1
  } db_state_e;

  // Event word as seen by the processor: {26'b0, ir_evt, sw_evt[4:0]}.
  function automatic logic [31:0] pack_evt(input logic ir_evt, input logic [4:0] sw_evt);
    return {26'b0, ir_evt, sw_evt};
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// Synchronizer plus debounce filter for one asynchronous input bit.
// Ports:
//   clk    : system clock
//   reset  : synchronous active-high reset
//   din    : raw asynchronous input
//   stable : debounced level (registered)
//   rise   : one-cycle pulse, high in the first cycle stable reads 1 after a 0->1 acceptance
// A new level is accepted once the synchronized input has disagreed with
// stable on DEBOUNCE_CYCLES consecutive clock edges.
module debounce_bit
  import input_map_pkg::*;
#(
  parameter  int DEBOUNCE_CYCLES = 250000,
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic stable,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1_reg;
  logic             sync2_reg;
  db_state_e        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             stable_reg, stable_next;
  logic             rise_reg, rise_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg  <= 1'b0;
      sync2_reg  <= 1'b0;
      state_reg  <= STABLE;
      cnt_reg    <= '0;
      stable_reg <= 1'b0;
      rise_reg   <= 1'b0;
    end else begin
      sync1_reg  <= din;
      sync2_reg  <= sync1_reg;
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      stable_reg <= stable_next;
      rise_reg   <= rise_next;
    end
  end

  // The edge that leaves STABLE already counts as the first disagreeing
  // edge, so the counter starts at 1 and the acceptance edge is the one
  // where it holds DEBOUNCE_CYCLES-1.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    stable_next = stable_reg;
    rise_next   = 1'b0;
    case (state_reg)
      STABLE: begin
        if (sync2_reg != stable_reg) begin
          state_next = COUNTING;
          cnt_next   = CNT_ONE;
        end else begin
          cnt_next = '0;
        end
      end
      COUNTING: begin
        if (sync2_reg == stable_reg) begin
          state_next = STABLE;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next  = STABLE;
          cnt_next    = '0;
          stable_next = sync2_reg;
          rise_next   = sync2_reg;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      default: begin
        state_next = STABLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign stable = stable_reg;
  assign rise   = rise_reg;

endmodule

// File: rtl/input_sampler_ctrl.sv
// Input sampling front end for the processor's memory-mapped input path.
// Ports:
//   clk       : system clock
//   reset     : synchronous active-high reset
//   sw[4:0]   : raw switch/button pins (asynchronous)
//   IR        : raw infrared sensor pin (asynchronous)
//   dir[4:0]  : processor data-memory word address
//   rd_en     : processor load strobe
//   sw_stable : debounced switch levels (load mux, address 30)
//   ir_stable : debounced IR level (load mux, address 29)
//   evt_data  : sticky rising-edge event register (load mux, address 31),
//               cleared by a load from address 31
module input_sampler_ctrl
  import input_map_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_SW-1:0] sw,
  input  logic              IR,
  input  logic [4:0]        dir,
  input  logic              rd_en,
  output logic [NUM_SW-1:0] sw_stable,
  output logic              ir_stable,
  output logic [31:0]       evt_data
);

  localparam int NUM_IN = NUM_SW + 1;

  // Bit NUM_SW is the IR line, lower bits are the switches.
  logic [NUM_IN-1:0] raw_in;
  logic [NUM_IN-1:0] stable_vec;
  logic [NUM_IN-1:0] rise_vec;
  logic [NUM_IN-1:0] flags_reg, flags_next;
  logic              clr_evt;

  assign raw_in = {IR, sw};

  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_db
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk   (clk),
      .reset (reset),
      .din   (raw_in[gi]),
      .stable(stable_vec[gi]),
      .rise  (rise_vec[gi])
    );
  end

  // Clearing takes effect at the edge ending the read cycle, so the load
  // captures the pre-clear word. A rise arriving on that same edge is ORed
  // in after the clear and therefore survives.
  assign clr_evt = rd_en && (dir == ADDR_EVT);

  always_comb begin
    flags_next = flags_reg;
    if (clr_evt) begin
      flags_next = '0;
    end
    flags_next = flags_next | rise_vec;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_reg <= '0;
    end else begin
      flags_reg <= flags_next;
    end
  end

  assign sw_stable = stable_vec[NUM_SW-1:0];
  assign ir_stable = stable_vec[NUM_SW];
  assign evt_data  = pack_evt(flags_reg[NUM_SW], flags_reg[NUM_SW-1:0]);

endmodule

// File: tb/tb_input_sampler_ctrl.sv
// Testbench for input_sampler_ctrl with DEBOUNCE_CYCLES = 4.
// Each vector holds the inputs driven for one clock cycle and the outputs
// expected just after the following rising edge.
module tb_input_sampler_ctrl;

  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  sw;
  logic        ir;
  logic [4:0]  dir;
  logic        rd_en;
  logic [4:0]  sw_stable;
  logic        ir_stable;
  logic [31:0] evt_data;

  always #5 clk = ~clk;

  input_sampler_ctrl #(
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .sw       (sw),
    .IR       (ir),
    .dir      (dir),
    .rd_en    (rd_en),
    .sw_stable(sw_stable),
    .ir_stable(ir_stable),
    .evt_data (evt_data)
  );

  typedef struct {
    logic        rst;
    logic [4:0]  sw;
    logic        ir;
    logic [4:0]  dir;
    logic        rd;
    logic [4:0]  esw;
    logic        eir;
    logic [31:0] eevt;
    string       tag;
  } vec_t;

  typedef struct {
    logic [4:0]  esw;
    logic        eir;
    logic [31:0] eevt;
    string       tag;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   txn    = 0;

  function automatic vec_t mk(input logic rst, input logic [4:0] s, input logic i,
                              input logic [4:0] d, input logic r, input logic [4:0] esw,
                              input logic eir, input logic [31:0] eevt, input string tag);
    vec_t v;
    v.rst = rst; v.sw = s; v.ir = i; v.dir = d; v.rd = r;
    v.esw = esw; v.eir = eir; v.eevt = eevt; v.tag = tag;
    return v;
  endfunction

  task automatic check_field(input string tag, input string what,
                             input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %h expected %h", tag, what, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    reset = v.rst; sw = v.sw; ir = v.ir; dir = v.dir; rd_en = v.rd;
    e.esw = v.esw; e.eir = v.eir; e.eevt = v.eevt; e.tag = v.tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_field(e.tag, "sw_stable", {27'b0, sw_stable}, {27'b0, e.esw});
    check_field(e.tag, "ir_stable", {31'b0, ir_stable}, {31'b0, e.eir});
    check_field(e.tag, "evt_data", evt_data, e.eevt);
    txn++;
    $display("txn %0d %s: sw=%b ir=%b rd=%b dir=%0d -> sw_stable=%b ir_stable=%b evt=%h",
             txn, e.tag, v.sw, v.ir, v.rd, v.dir, sw_stable, ir_stable, evt_data);
  endtask

  task automatic step(input logic rst, input logic [4:0] s, input logic i,
                      input logic [4:0] d, input logic r, input logic [4:0] esw,
                      input logic eir, input logic [31:0] eevt, input string tag);
    apply(mk(rst, s, i, d, r, esw, eir, eevt, tag));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // ---------------- table ----------------
    // Reset held with all inputs high: outputs stay 0.
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(1, 5'h1F, 1, 5'd0, 0, 5'h00, 0, 32'h0, "reset_hold"));
    // After release: stable on the 6th edge, flags one edge later.
    for (int k = 1; k <= 7; k++)
      vecs.push_back(mk(0, 5'h1F, 1, 5'd0, 0, (k >= 6) ? 5'h1F : 5'h00, (k >= 6),
                        (k >= 7) ? 32'h3F : 32'h0, "reset_release"));
    // Reads of 30 and 29 leave flags alone; read of 31 clears.
    vecs.push_back(mk(0, 5'h1F, 1, 5'd30, 1, 5'h1F, 1, 32'h3F, "read30"));
    vecs.push_back(mk(0, 5'h1F, 1, 5'd29, 1, 5'h1F, 1, 32'h3F, "read29"));
    vecs.push_back(mk(0, 5'h1F, 1, 5'd31, 0, 5'h1F, 1, 32'h3F, "dir31_no_rd"));
    vecs.push_back(mk(0, 5'h1F, 1, 5'd31, 1, 5'h1F, 1, 32'h0, "read31_clear"));
    // Clean restart.
    for (int k = 0; k < 2; k++)
      vecs.push_back(mk(1, 5'h00, 0, 5'd0, 0, 5'h00, 0, 32'h0, "reset_clean"));
    // Three-cycle glitch on sw[2] is rejected.
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(0, 5'h04, 0, 5'd0, 0, 5'h00, 0, 32'h0, "glitch_hi"));
    for (int k = 0; k < 6; k++)
      vecs.push_back(mk(0, 5'h00, 0, 5'd0, 0, 5'h00, 0, 32'h0, "glitch_lo"));
    // IR press accepted.
    for (int k = 1; k <= 7; k++)
      vecs.push_back(mk(0, 5'h00, 1, 5'd0, 0, 5'h00, (k >= 6),
                        (k >= 7) ? 32'h20 : 32'h0, "ir_press"));
    vecs.push_back(mk(0, 5'h00, 1, 5'd31, 1, 5'h00, 1, 32'h0, "clear_ir"));
    // sw[0] press, then read-clear checks with evt_data = 01.
    for (int k = 1; k <= 7; k++)
      vecs.push_back(mk(0, 5'h01, 1, 5'd0, 0, (k >= 6) ? 5'h01 : 5'h00, 1,
                        (k >= 7) ? 32'h01 : 32'h0, "sw0_press"));
    vecs.push_back(mk(0, 5'h01, 1, 5'd30, 1, 5'h01, 1, 32'h01, "sw0_read30"));
    vecs.push_back(mk(0, 5'h01, 1, 5'd31, 1, 5'h01, 1, 32'h00, "sw0_read31"));
    // IR release: stable falls, no event.
    for (int k = 1; k <= 7; k++)
      vecs.push_back(mk(0, 5'h01, 0, 5'd0, 0, 5'h01, (k < 6), 32'h0, "ir_release"));

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i]);

    // ---------------- set wins over clear ----------------
    step(1, 5'h00, 0, 5'd0, 0, 5'h00, 0, 32'h0, "sw_reset");
    step(1, 5'h00, 0, 5'd0, 0, 5'h00, 0, 32'h0, "sw_reset");
    step(0, 5'h01, 0, 5'd0, 0, 5'h00, 0, 32'h0, "collide");
    for (int k = 2; k <= 5; k++)
      step(0, 5'h11, 0, 5'd0, 0, 5'h00, 0, 32'h0, "collide");
    step(0, 5'h11, 0, 5'd0, 0, 5'h01, 0, 32'h00, "collide_sw0_up");
    step(0, 5'h11, 0, 5'd0, 0, 5'h11, 0, 32'h01, "collide_sw4_up");
    step(0, 5'h11, 0, 5'd31, 1, 5'h11, 0, 32'h10, "collide_clear");
    step(0, 5'h11, 0, 5'd0, 0, 5'h11, 0, 32'h10, "collide_after");

    // ---------------- reset mid-count ----------------
    step(1, 5'h00, 0, 5'd0, 0, 5'h00, 0, 32'h0, "mid_reset_pre");
    step(1, 5'h00, 0, 5'd0, 0, 5'h00, 0, 32'h0, "mid_reset_pre");
    for (int k = 0; k < 4; k++)
      step(0, 5'h02, 0, 5'd0, 0, 5'h00, 0, 32'h0, "mid_count");
    step(1, 5'h02, 0, 5'd0, 0, 5'h00, 0, 32'h0, "mid_reset");
    step(1, 5'h02, 0, 5'd0, 0, 5'h00, 0, 32'h0, "mid_reset");
    for (int k = 1; k <= 7; k++)
      step(0, 5'h02, 0, 5'd0, 0, (k >= 6) ? 5'h02 : 5'h00, 0,
           (k >= 7) ? 32'h02 : 32'h0, "mid_refresh");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
